// File: rtl/alu_issue_stage.sv
// Two-stage issue/writeback controller in front of a 4-bit combinational ALU.
// Holds a 4x4 register file, stalls one cycle on a RAW hazard against execute.
module alu_issue_stage #(
    parameter int NREG  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_imm,
    input  logic [1:0]       in_op,
    input  logic [1:0]       in_rd,
    input  logic [1:0]       in_rs1,
    input  logic [1:0]       in_rs2,
    input  logic [3:0]       in_data,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_select,
    input  logic [3:0]       alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_sign,
    input  logic             alu_parity,
    input  logic             alu_overflow,
    output logic             wb_valid,
    output logic [1:0]       wb_rd,
    output logic [3:0]       wb_data,
    output logic [4:0]       flags,
    output logic [CNT_W-1:0] retire_cnt
);

    logic [3:0] rf [NREG];

    logic       ex_valid;
    logic       ex_imm;
    logic [1:0] ex_rd;
    logic [3:0] ex_data;

    logic       hazard;
    logic       accept;
    logic [3:0] rs1_val;
    logic [3:0] rs2_val;
    logic [3:0] wb_value;
    logic [4:0] alu_flags;

    assign rs1_val = rf[in_rs1];
    assign rs2_val = rf[in_rs2];

    // Immediate loads read no registers, so they can never hit the hazard.
    assign hazard   = ex_valid && !in_imm && ((in_rs1 == ex_rd) || (in_rs2 == ex_rd));
    assign in_ready = !reset && !hazard;
    assign accept   = in_valid && in_ready;

    assign wb_value  = ex_imm ? ex_data : alu_out;
    assign alu_flags = {alu_overflow, alu_parity, alu_sign, alu_carry, alu_zero};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            ex_valid   <= 1'b0;
            ex_imm     <= 1'b0;
            ex_rd      <= '0;
            ex_data    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            flags      <= '0;
            retire_cnt <= '0;
        end else begin
            ex_valid <= accept;
            if (accept) begin
                ex_imm     <= in_imm;
                ex_rd      <= in_rd;
                ex_data    <= in_data;
                alu_a      <= rs1_val;
                alu_b      <= rs2_val;
                alu_select <= in_op;
            end

            // Retirement of whatever sat in execute during this cycle.
            wb_valid <= ex_valid;
            if (ex_valid) begin
                rf[ex_rd]  <= wb_value;
                wb_rd      <= ex_rd;
                wb_data    <= wb_value;
                retire_cnt <= retire_cnt + CNT_W'(1);
                if (!ex_imm) begin
                    flags <= alu_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: acts as upstream issuer and as the ALU,
// comparing retirements against a sequential instruction-level reference model.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_imm;
    logic [1:0] in_op, in_rd, in_rs1, in_rs2;
    logic [3:0] in_data;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_select;
    logic [3:0] alu_out;
    logic       alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [3:0] wb_data;
    logic [4:0] flags;
    logic [7:0] retire_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    alu_issue_stage #(.NREG(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_data(in_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
        .alu_parity(alu_parity), .alu_overflow(alu_overflow),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flags(flags), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU behaviour: returns {overflow, parity, sign, carry, zero, out[3:0]}
    function automatic logic [8:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] o;
        logic c, ov;
        c = 1'b0; ov = 1'b0;
        case (op)
            2'b00: begin s = {1'b0, a} + {1'b0, b}; o = s[3:0]; c = s[4]; ov = (a[3] == b[3]) && (o[3] != a[3]); end
            2'b01: begin s = {1'b0, a} - {1'b0, b}; o = s[3:0]; c = s[4]; ov = (a[3] != b[3]) && (o[3] != a[3]); end
            2'b10: o = a & b;
            default: o = a | b;
        endcase
        return {ov, ^o, o[3], c, (o == 4'd0), o};
    endfunction

    always_comb begin
        logic [8:0] r;
        r = alu_f(alu_select, alu_a, alu_b);
        alu_out = r[3:0];
        {alu_overflow, alu_parity, alu_sign, alu_carry, alu_zero} = r[8:4];
    end

    // Reference model: architectural state of a sequential machine.
    logic [3:0] m_rf [4];
    logic [4:0] m_flags;
    logic [7:0] m_cnt;
    logic [5:0] exp_q[$];
    logic [5:0] obs_q[$];
    int         obs_cyc[$];
    logic [1:0] last_rd;
    bit         last_live;
    int         acc_cyc;

    always @(posedge clk) begin
        #1;
        if (wb_valid === 1'b1) begin
            obs_q.push_back({wb_rd, wb_data});
            obs_cyc.push_back(cyc);
        end
    end

    function automatic int exp_stall(input bit imm, input logic [1:0] rs1, input logic [1:0] rs2);
        return (!imm && last_live && (rs1 == last_rd || rs2 == last_rd)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
        m_flags = 5'd0;
        m_cnt = 8'd0;
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        last_live = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            last_live = 0;
        end
    endtask

    // Drives one instruction until accepted; stalls=99 marks a timeout.
    task automatic issue(input bit imm, input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] data,
                         output int stalls);
        logic [8:0] r;
        stalls = 0;
        in_valid = 1'b1; in_imm = imm; in_op = op; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; in_data = data;
        while (1) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            stalls++;
            if (stalls > 8) begin
                stalls = 99;
                in_valid = 1'b0;
                @(posedge clk); #1;
                last_live = 0;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc = cyc;
        if (imm) begin
            m_rf[rd] = data;
        end else begin
            r = alu_f(op, m_rf[rs1], m_rf[rs2]);
            m_rf[rd] = r[3:0];
            m_flags = r[8:4];
        end
        exp_q.push_back({rd, m_rf[rd]});
        m_cnt++;
        last_rd = rd;
        last_live = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1; in_imm = 1'b1; in_op = 2'd0; in_rd = 2'd1;
        in_rs1 = 2'd2; in_rs2 = 2'd3; in_data = 4'hA;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready actual=%b required=0", in_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid actual=%b required=0", wb_valid); end
        checks++; if (flags !== 5'd0) begin errors++; $display("FAIL reset_flags actual=%b required=00000", flags); end
        checks++; if (retire_cnt !== 8'd0) begin errors++; $display("FAIL reset_retire_cnt actual=%0d required=0", retire_cnt); end
        checks++; if (alu_a !== 4'd0 || alu_b !== 4'd0 || alu_select !== 2'd0)
            begin errors++; $display("FAIL reset_alu_inputs actual=%h/%h/%h required=0/0/0", alu_a, alu_b, alu_select); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready actual=%b required=1", in_ready); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_imm_alu();
        int st;
        issue(1, 2'd0, 2'd1, 2'd0, 2'd0, 4'd3, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL imm_li1_stall actual=%0d required=0", st); end
        issue(1, 2'd0, 2'd2, 2'd0, 2'd0, 4'd5, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL imm_li2_stall actual=%0d required=0", st); end
        issue(0, 2'd0, 2'd3, 2'd1, 2'd2, 4'd0, st);
        checks++; if (st !== 1) begin errors++; $display("FAIL imm_add_stall actual=%0d required=1", st); end
        idle(3);
        checks++; if (obs_q.size() != 3 || exp_q.size() != 3)
            begin errors++; $display("FAIL imm_wb_count actual=%0d required=3", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL imm_wb[%0d] actual=%h required=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (obs_q.size() == 3 && obs_q[2] !== {2'd3, 4'b1000})
            begin errors++; $display("FAIL imm_add_result actual=%h required=%h", obs_q[2], {2'd3, 4'b1000}); end
        checks++; if (obs_cyc.size() == 3 && obs_cyc[2] != acc_cyc + 1)
            begin errors++; $display("FAIL imm_latency actual=%0d required=%0d", obs_cyc[2], acc_cyc + 1); end
        checks++; if (flags !== m_flags || flags[1:0] !== 2'b00)
            begin errors++; $display("FAIL imm_flags actual=%b required=%b", flags, m_flags); end
        checks++; if (retire_cnt !== 8'd3) begin errors++; $display("FAIL imm_retire_cnt actual=%0d required=3", retire_cnt); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_hazard();
        int st;
        issue(0, 2'd0, 2'd3, 2'd1, 2'd2, 4'd0, st);
        checks++; if (st !== exp_stall(0, 2'd1, 2'd2) && st !== 0) begin errors++; $display("FAIL hz_add_stall actual=%0d required=0", st); end
        issue(0, 2'd1, 2'd0, 2'd3, 2'd1, 4'd0, st);
        checks++; if (st !== 1) begin errors++; $display("FAIL hz_sub_stall actual=%0d required=1", st); end
        issue(0, 2'd2, 2'd2, 2'd0, 2'd1, 4'd0, st);
        checks++; if (st !== 1) begin errors++; $display("FAIL hz_and_stall actual=%0d required=1", st); end
        idle(3);
        checks++; if (obs_q.size() != exp_q.size())
            begin errors++; $display("FAIL hz_wb_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL hz_wb[%0d] actual=%h required=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (obs_q.size() == 3 && (obs_q[1] !== {2'd0, 4'd5} || obs_q[2] !== {2'd2, 4'd1}))
            begin errors++; $display("FAIL hz_values actual=%h,%h required=05,21", obs_q[1], obs_q[2]); end
        checks++; if (flags !== m_flags) begin errors++; $display("FAIL hz_flags actual=%b required=%b", flags, m_flags); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_throughput();
        int st, total;
        do_reset(2);
        total = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1, 2'($urandom_range(0, 3)), 2'(i % 2), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), st);
            total += st;
        end
        checks++; if (total != 0) begin errors++; $display("FAIL tp_stalls actual=%0d required=0", total); end
        idle(3);
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL tp_wb_count actual=%0d required=8", obs_q.size()); end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            checks++; if (obs_cyc[i] != obs_cyc[i-1] + 1)
                begin errors++; $display("FAIL tp_consecutive[%0d] actual=%0d required=%0d", i, obs_cyc[i], obs_cyc[i-1] + 1); end
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL tp_wb[%0d] actual=%h required=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (retire_cnt !== 8'd8) begin errors++; $display("FAIL tp_retire_cnt actual=%0d required=8", retire_cnt); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset_mid();
        int st;
        for (int r = 0; r < 4; r++) issue(1, 2'd0, 2'(r), 2'd0, 2'd0, 4'($urandom_range(1, 15)), st);
        issue(0, 2'd0, 2'd2, 2'd1, 2'd3, 4'd0, st);
        idle(3);
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        issue(0, 2'd1, 2'd1, 2'd1, 2'd1, 4'd0, st);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        idle(2);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_reset_wb actual=%0d required=0", obs_q.size()); end
        checks++; if (flags !== 5'd0) begin errors++; $display("FAIL mid_reset_flags actual=%b required=00000", flags); end
        checks++; if (retire_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_cnt actual=%0d required=0", retire_cnt); end
        // OR ri=ri|ri exposes each register's post-reset content.
        for (int r = 0; r < 4; r++) issue(0, 2'd3, 2'(r), 2'(r), 2'(r), 4'd0, st);
        idle(3);
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL mid_rf_count actual=%0d required=4", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_rf[%0d] actual=%h required=%h", i, obs_q[i], exp_q[i]); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_random();
        int st, es;
        for (int n = 0; n < 80; n++) begin
            bit imm;
            logic [1:0] op, rd, rs1, rs2;
            imm = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3)); rd = 2'($urandom_range(0, 3));
            rs1 = 2'($urandom_range(0, 3)); rs2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle(1);
            es = exp_stall(imm, rs1, rs2);
            issue(imm, op, rd, rs1, rs2, 4'($urandom_range(0, 15)), st);
            checks++; if (st != es) begin errors++; $display("FAIL rnd_stall[%0d] actual=%0d required=%0d", n, st, es); end
        end
        idle(3);
        checks++; if (obs_q.size() != exp_q.size())
            begin errors++; $display("FAIL rnd_wb_count actual=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_wb[%0d] actual=%h required=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (flags !== m_flags) begin errors++; $display("FAIL rnd_flags actual=%b required=%b", flags, m_flags); end
        checks++; if (retire_cnt !== m_cnt) begin errors++; $display("FAIL rnd_retire_cnt actual=%0d required=%0d", retire_cnt, m_cnt); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_wrap();
        int st, bad;
        do_reset(2);
        issue(1, 2'd0, 2'd1, 2'd0, 2'd0, 4'd6, st);
        issue(0, 2'd1, 2'd1, 2'd1, 2'd1, 4'd0, st);
        for (int n = 0; n < 253; n++)
            issue(1, 2'd0, 2'($urandom_range(0, 3)), 2'd0, 2'd0, 4'($urandom_range(0, 15)), st);
        idle(3);
        checks++; if (retire_cnt !== 8'd255) begin errors++; $display("FAIL wrap_cnt_255 actual=%0d required=255", retire_cnt); end
        checks++; if (flags !== m_flags || flags[0] !== 1'b1)
            begin errors++; $display("FAIL wrap_flags_hold actual=%b required=%b", flags, m_flags); end
        issue(1, 2'd0, 2'd2, 2'd0, 2'd0, 4'd9, st);
        idle(3);
        checks++; if (retire_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt_0 actual=%0d required=0", retire_cnt); end
        checks++; if (flags !== 5'b00011 && flags !== m_flags)
            begin errors++; $display("FAIL wrap_flags_after actual=%b required=%b", flags, m_flags); end
        checks++; if (obs_q.size() != 256) begin errors++; $display("FAIL wrap_wb_count actual=%0d required=256", obs_q.size()); end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_wb_values actual=%0d_bad required=0_bad", bad); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_imm = 1'b0; in_op = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_data = '0;
        last_rd = '0; acc_cyc = 0;
        model_reset();
        test_reset();
        test_imm_alu();
        test_hazard();
        test_throughput();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Two-stage issue and writeback controller that sits directly upstream of the 4-bit combinational `alu`. It accepts register-to-register instructions over a valid/ready handshake and holds a 4-entry × 4-bit register file. It drives the ALU operand and select inputs from a registered execute stage, then writes `out` and the five flags back. Read-after-write hazards against the in-flight instruction are resolved by a one-cycle stall.

## Interface
- `NREG`, 4: register-file depth; fixed at 4, so register indices are 2 bits.
- `CNT_W`, 8: width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  block can accept the instruction this cycle.
- `in_imm`  in  1  1 = load immediate, 0 = ALU operation.
- `in_op`  in  2  ALU select: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `in_rd`, `in_rs1`, `in_rs2`  in  2 each  destination and source register indices.
- `in_data`  in  4  immediate value; used only when `in_imm`=1.
- `alu_a`, `alu_b`  out  4 each  registered operands to the ALU.
- `alu_select`  out  2  registered ALU select.
- `alu_out`  in  4  ALU result.
- `alu_zero`, `alu_carry`, `alu_sign`, `alu_parity`, `alu_overflow`  in  1 each  ALU flags.
- `wb_valid`  out  1  one-cycle pulse when an instruction retires.
- `wb_rd`  out  2  register written at retirement.
- `wb_data`  out  4  value written at retirement.
- `flags`  out  5  {overflow, parity, sign, carry, zero}, sticky until the next ALU retirement.
- `retire_cnt`  out  CNT_W  count of retired instructions; wraps.

## Operation
- Instructions are accepted on any cycle where `in_valid` and `in_ready` are both high.
- Decode stage, combinational:
  - Reads `rf[in_rs1]` and `rf[in_rs2]`.
  - `in_ready` = !reset && !(ex_valid && !in_imm && (in_rs1==ex_rd || in_rs2==ex_rd)).
  - Immediate loads never stall.
- Execute-stage registers, loaded on accept: ex_valid, ex_imm, ex_rd, ex_data, plus `alu_a`/`alu_b`/`alu_select` = rf[rs1], rf[rs2], in_op.
- If no instruction is accepted, ex_valid clears. `alu_*` outputs hold their last value.
- Writeback, at the edge that ends a cycle with ex_valid=1:
  - rf[ex_rd] is written with `alu_out`, or with ex_data when ex_imm=1.
  - `wb_valid`=1, with `wb_rd` and `wb_data` set to the written register and value.
  - `retire_cnt` increments.
- `flags` is updated from the `alu_*` flags only on ALU retirements. Immediate loads leave `flags` unchanged.
- Writeback and a new accept may occur at the same edge. The decode read in that cycle sees the old rf value, which is exactly the case the stall rule excludes.
- rd == rs is legal; for example ADD r1=r1+r1 reads the old value.
- Register r0 is an ordinary register, not hardwired to zero.
- Arithmetic is 4-bit modulo in the ALU. This block performs no arithmetic apart from the counter.
- `retire_cnt` wraps from 2^CNT_W−1 to 0.
- Flag reset value is 5'b00000.

## Timing
- Reset values (all synchronous, while `reset`=1):
  - All rf entries 0; ex_valid 0.
  - `alu_a`, `alu_b`, `alu_select`, `wb_valid`, `wb_rd`, `wb_data`, `flags`, `retire_cnt` all 0.
  - `in_ready` 0.
- Reset asserted while an instruction is in execute drops it: no `wb_valid`, no rf write.
- Latency: accept at edge N → ALU inputs valid during cycle N..N+1 → rf write, `wb_valid`, and `flags` at edge N+1. The result is visible in the cycle after acceptance-plus-one.
- Throughput: 1 instruction/cycle with no hazards.
- A dependent instruction immediately following its producer sees `in_ready`=0 for exactly one cycle, then is accepted.
- `in_ready` depends combinationally on the `in_*` fields. Upstream must hold the instruction stable while `in_valid`=1 and `in_ready`=0.
- `wb_valid` is high for exactly one cycle per retired instruction.

## Test plan
- Reset: hold `reset` 3 cycles with `in_valid`=1 → `in_ready`=0, `wb_valid`=0, `flags`=0, `retire_cnt`=0, `alu_a`=`alu_b`=0; after release `in_ready`=1.
- Immediate plus ALU op:
  - LI r1=3, then LI r2=5, then ADD r3=r1+r2 (non-dependent on r2? r2 written one cycle earlier, stalls one cycle).
  - Expect: `wb_data` 3, then 5, then 4'b1000 with `wb_rd`=3; `flags.zero`=0, `flags.carry`=0; `retire_cnt`=3.
- Hazard stall: after r3=8, issue SUB r0=r3−r1 back-to-back with the ADD → `in_ready` low exactly 1 cycle; retires `wb_data`=5 to r0. AND r2=r0&r1 then gives 1.
- Throughput: 8 independent LI instructions to alternating r0/r1 back-to-back → `in_ready` never drops, 8 consecutive `wb_valid` pulses, `retire_cnt`=8.
- Reset mid-operation: accept SUB r1=r1−r1, assert `reset` on the next edge → no `wb_valid`, rf all 0, `flags` 0.
- Counter wrap: retire 256 LI instructions → `retire_cnt` goes 255 → 0. Flags from the last ALU op (SUB r1=r1−r1, `zero`=1) stay unchanged through the LIs.
